// File: rtl/pwls_channel_scheduler.sv
// pwls_channel_scheduler
// Sequences the shared multichannel ALU over NUM_CH channels once per sample
// period and slots host register-file writes into the gaps between sweeps.
// Optional feature macro: PWLS_SCHED_MIDSWEEP_WRITE_EN -- when defined, host
// writes are also accepted on the last step of every channel except the last
// one, inserting a single WRITE cycle before the sweep resumes.
module pwls_channel_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int STEPS      = 8,
    parameter int SAMPLE_DIV = 64,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ST_W      = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            overrun_clr,
    input  logic            wr_valid,
    input  logic [7:0]      wr_addr,
    input  logic [15:0]     wr_data,
    output logic            wr_ready,
    output logic            reg_we,
    output logic [7:0]      reg_waddr,
    output logic [15:0]     reg_wdata,
    output logic [CH_W-1:0] ch_sel,
    output logic [ST_W-1:0] step,
    output logic            alu_en,
    output logic            acc_clear,
    output logic            out_latch,
    output logic            busy,
    output logic            overrun
);

`ifdef PWLS_SCHED_MIDSWEEP_WRITE_EN
    localparam bit MIDSWEEP_WR = 1'b1;
`else
    localparam bit MIDSWEEP_WR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [ST_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             out_latch_q, out_latch_d;
    logic             resume_q, resume_d;
    logic [7:0]       waddr_q, waddr_d;
    logic [15:0]      wdata_q, wdata_d;

    logic tick;
    logic last_step;
    logic last_ch;
    logic mid_slot;
    logic xfer;
    logic consume;

    assign tick      = en && (cnt_q == CNT_LAST);
    assign last_step = (step_q == ST_LAST);
    assign last_ch   = (ch_q == CH_LAST);
    // Channel boundary inside a sweep where a host write may be squeezed in.
    assign mid_slot  = MIDSWEEP_WR && (state_q == S_RUN) && last_step && !last_ch;
    // Gated by rst_n so the handshake reads 0 while reset is held.
    assign wr_ready  = rst_n && (((state_q == S_IDLE) && !pending_q) || mid_slot);
    assign xfer      = wr_valid && wr_ready;

    // Sample timebase, pending-sweep request and sticky overrun flag.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        pending_d = pending_q;
        if (tick) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (tick && pending_q) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Sweep/write sequencer next state; pending sweep has priority over writes.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        step_d      = step_q;
        resume_d    = resume_q;
        out_latch_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        consume     = 1'b0;

        if (xfer) begin
            waddr_d = wr_addr;
            wdata_d = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                ch_d     = '0;
                step_d   = '0;
                resume_d = 1'b0;
                if (pending_q) begin
                    state_d = S_RUN;
                    consume = 1'b1;
                end else if (wr_valid) begin
                    state_d = S_WRITE;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    step_d = '0;
                    if (last_ch) begin
                        state_d     = S_IDLE;
                        ch_d        = '0;
                        out_latch_d = 1'b1;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                        if (xfer) begin
                            state_d  = S_WRITE;
                            resume_d = 1'b1;
                        end
                    end
                end else begin
                    step_d = step_q + ST_W'(1);
                end
            end
            S_WRITE: begin
                state_d  = resume_q ? S_RUN : S_IDLE;
                resume_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any sweep or write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            out_latch_q <= 1'b0;
            resume_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            out_latch_q <= out_latch_d;
            resume_q    <= resume_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // ch_q/step_q keep the resume point during a mid-sweep WRITE, so mask them.
    assign alu_en    = (state_q == S_RUN);
    assign ch_sel    = alu_en ? ch_q : '0;
    assign step      = alu_en ? step_q : '0;
    assign acc_clear = alu_en && (ch_q == '0) && (step_q == '0);
    assign reg_we    = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign out_latch = out_latch_q;
    assign overrun   = overrun_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_pwls_channel_scheduler.sv
// Bench for pwls_channel_scheduler: two instances (SAMPLE_DIV 64 and 16) share
// one stimulus stream and are compared each cycle against a sweep-position model.
module tb_pwls_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int STEPS  = 8;
    localparam int TOT    = NUM_CH * STEPS;
    localparam int DIV0   = 64;
    localparam int DIV1   = 16;
`ifdef PWLS_SCHED_MIDSWEEP_WRITE_EN
    localparam bit MID     = 1'b1;
    localparam int HS_EXP  = 72;
    localparam int LAT_EXP = 98;
`else
    localparam bit MID     = 1'b0;
    localparam int HS_EXP  = 97;
    localparam int LAT_EXP = 97;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        ocl = 1'b0;
    logic        wv = 1'b0;
    logic [7:0]  wa = '0;
    logic [15:0] wd = '0;

    logic        rdy [2];
    logic        we  [2];
    logic [7:0]  waddr [2];
    logic [15:0] wdata [2];
    logic [1:0]  chs [2];
    logic [2:0]  stp [2];
    logic        alu [2];
    logic        accc [2];
    logic        olat [2];
    logic        bsy [2];
    logic        ovr [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int snap_cyc = 0;
    logic [35:0] snap0, snap1;

    // behavioural model: mode 0 idle, 1 sweeping, 2 writing; pos = linear sweep index
    int          m_cnt [2];
    int          m_mode [2];
    int          m_pos [2];
    bit          m_pend [2];
    bit          m_ovr [2];
    bit          m_res [2];
    bit          m_lat [2];
    logic [7:0]  m_wa [2];
    logic [15:0] m_wd [2];

    always #5 clk = ~clk;

    pwls_channel_scheduler #(.NUM_CH(NUM_CH), .STEPS(STEPS), .SAMPLE_DIV(DIV0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .overrun_clr(ocl),
        .wr_valid(wv), .wr_addr(wa), .wr_data(wd), .wr_ready(rdy[0]),
        .reg_we(we[0]), .reg_waddr(waddr[0]), .reg_wdata(wdata[0]),
        .ch_sel(chs[0]), .step(stp[0]), .alu_en(alu[0]), .acc_clear(accc[0]),
        .out_latch(olat[0]), .busy(bsy[0]), .overrun(ovr[0])
    );

    pwls_channel_scheduler #(.NUM_CH(NUM_CH), .STEPS(STEPS), .SAMPLE_DIV(DIV1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .overrun_clr(ocl),
        .wr_valid(wv), .wr_addr(wa), .wr_data(wd), .wr_ready(rdy[1]),
        .reg_we(we[1]), .reg_waddr(waddr[1]), .reg_wdata(wdata[1]),
        .ch_sel(chs[1]), .step(stp[1]), .alu_en(alu[1]), .acc_clear(accc[1]),
        .out_latch(olat[1]), .busy(bsy[1]), .overrun(ovr[1])
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [35:0] obs_vec(input int i);
        return {rdy[i], we[i], waddr[i], wdata[i], chs[i], stp[i],
                alu[i], accc[i], olat[i], bsy[i], ovr[i]};
    endfunction

    function automatic logic m_ready(input int i);
        logic idle_ok, mid_ok;
        idle_ok = (m_mode[i] == 0) && !m_pend[i];
        mid_ok  = MID && (m_mode[i] == 1) && ((m_pos[i] % STEPS) == STEPS - 1)
                  && ((m_pos[i] / STEPS) < NUM_CH - 1);
        return rst_n && (idle_ok || mid_ok);
    endfunction

    function automatic logic [35:0] exp_vec(input int i);
        logic       run;
        logic [1:0] ech;
        logic [2:0] est;
        run = (m_mode[i] == 1);
        ech = run ? 2'(m_pos[i] / STEPS) : 2'd0;
        est = run ? 3'(m_pos[i] % STEPS) : 3'd0;
        return {m_ready(i), (m_mode[i] == 2), m_wa[i], m_wd[i], ech, est,
                run, run && (m_pos[i] == 0), m_lat[i], (m_mode[i] != 0), m_ovr[i]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_mode[i] = 0; m_pos[i] = 0; m_pend[i] = 0;
            m_ovr[i] = 0; m_res[i] = 0; m_lat[i] = 0; m_wa[i] = '0; m_wd[i] = '0;
        end
    endtask

    task automatic m_step(input int i, input int div);
        bit tk, xf, consumed;
        tk = en && (m_cnt[i] == div - 1);
        xf = wv && m_ready(i);
        consumed = 0;
        m_cnt[i] = en ? (m_cnt[i] + 1) % div : 0;
        if (tk && m_pend[i]) m_ovr[i] = 1;
        else if (ocl) m_ovr[i] = 0;
        if (xf) begin
            m_wa[i] = wa;
            m_wd[i] = wd;
        end
        m_lat[i] = 0;
        case (m_mode[i])
            0: begin
                if (m_pend[i]) begin
                    m_mode[i] = 1; m_pos[i] = 0; consumed = 1;
                end else if (wv) begin
                    m_mode[i] = 2; m_res[i] = 0;
                end
            end
            1: begin
                if (m_pos[i] == TOT - 1) begin
                    m_mode[i] = 0; m_lat[i] = 1;
                end else begin
                    m_pos[i]++;
                    if (xf) begin
                        m_mode[i] = 2; m_res[i] = 1;
                    end
                end
            end
            default: begin
                m_mode[i] = m_res[i] ? 1 : 0;
                m_res[i] = 0;
            end
        endcase
        if (tk) m_pend[i] = 1;
        else if (consumed) m_pend[i] = 0;
    endtask

    task automatic cmp_inst(input int i, input logic [35:0] o);
        logic [35:0] e;
        e = exp_vec(i);
        chk_eq($sformatf("i%0d_wr_ready", i),  o[35],    e[35]);
        chk_eq($sformatf("i%0d_reg_we", i),    o[34],    e[34]);
        chk_eq($sformatf("i%0d_reg_waddr", i), o[33:26], e[33:26]);
        chk_eq($sformatf("i%0d_reg_wdata", i), o[25:10], e[25:10]);
        chk_eq($sformatf("i%0d_ch_sel", i),    o[9:8],   e[9:8]);
        chk_eq($sformatf("i%0d_step", i),      o[7:5],   e[7:5]);
        chk_eq($sformatf("i%0d_alu_en", i),    o[4],     e[4]);
        chk_eq($sformatf("i%0d_acc_clear", i), o[3],     e[3]);
        chk_eq($sformatf("i%0d_out_latch", i), o[2],     e[2]);
        chk_eq($sformatf("i%0d_busy", i),      o[1],     e[1]);
        chk_eq($sformatf("i%0d_overrun", i),   o[0],     e[0]);
    endtask

    // Called at a negedge with inputs for this cycle already driven.
    task automatic do_cycle();
        #1;
        if (!rst_n) m_reset();
        snap0 = obs_vec(0);
        snap1 = obs_vec(1);
        snap_cyc = cyc;
        cmp_inst(0, snap0);
        cmp_inst(1, snap1);
        if (rst_n) begin
            m_step(0, DIV0);
            m_step(1, DIV1);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; wv = 1'b0; ocl = 1'b0;
        do_cycle();
        chk_eq("rst_outs0", snap0, 36'd0);
        chk_eq("rst_outs1", snap1, 36'd0);
        do_cycle();
        rst_n = 1'b1;
        en = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int first_acc, second_acc, first_lat, alu_n;
        logic o47, o48, o100, o101, o112;
        int hs, we_c, lat_b, nlat;
        logic r5, we6, we7, r64, we61;
        logic [35:0] s6, s61;
        bit found;

        m_reset();
        #2;
        rst_n = 1'b0;
        @(negedge clk);

        // Phase A: free-running sweeps, overrun on the SAMPLE_DIV=16 instance.
        do_reset();
        first_acc = -1; second_acc = -1; first_lat = -1; alu_n = 0;
        o47 = 1'bx; o48 = 1'bx; o100 = 1'bx; o101 = 1'bx; o112 = 1'bx;
        for (int c = 0; c < 200; c++) begin
            ocl = (c == 100) || (c == 111);
            do_cycle();
            if (snap0[3]) begin
                if (first_acc < 0) first_acc = snap_cyc;
                else if (second_acc < 0) second_acc = snap_cyc;
            end
            if (snap0[2] && first_lat < 0) first_lat = snap_cyc;
            if (snap0[4] && snap_cyc < 128) alu_n++;
            if (snap_cyc == 47)  o47  = snap1[0];
            if (snap_cyc == 48)  o48  = snap1[0];
            if (snap_cyc == 100) o100 = snap1[0];
            if (snap_cyc == 101) o101 = snap1[0];
            if (snap_cyc == 112) o112 = snap1[0];
        end
        ocl = 1'b0;
        chk_eq("a_first_acc_clear", first_acc, 65);
        chk_eq("a_second_acc_clear", second_acc, 129);
        chk_eq("a_first_out_latch", first_lat, 97);
        chk_eq("a_alu_en_cycles", alu_n, 32);
        chk_eq("a_ovr_c47", o47, 1'b0);
        chk_eq("a_ovr_c48", o48, 1'b1);
        chk_eq("a_ovr_c100", o100, 1'b1);
        chk_eq("a_ovr_cleared", o101, 1'b0);
        chk_eq("a_ovr_set_wins", o112, 1'b1);

        // Phase B: host writes in IDLE, and a write blocked by a pending sweep.
        do_reset();
        hs = -1; we_c = -1; lat_b = -1;
        r5 = 1'bx; we7 = 1'bx; r64 = 1'bx; s6 = '0; s61 = '0;
        for (int c = 0; c < 140; c++) begin
            wv = (c == 5) || (c == 60) || (c >= 64 && hs < 0);
            if (c == 5) begin wa = 8'h12; wd = 16'hBEEF; end
            else if (c == 60) begin wa = 8'h34; wd = 16'h1234; end
            else if (c >= 64) begin wa = 8'h56; wd = 16'hCAFE; end
            do_cycle();
            if (snap_cyc == 5)  r5 = snap0[35];
            if (snap_cyc == 6)  s6 = snap0;
            if (snap_cyc == 7)  we7 = snap0[34];
            if (snap_cyc == 61) s61 = snap0;
            if (snap_cyc == 64) r64 = snap0[35];
            if (snap_cyc >= 64 && hs < 0 && snap0[35]) hs = snap_cyc;
            if (snap0[34] && snap0[33:26] == 8'h56 && we_c < 0) we_c = snap_cyc;
            if (snap0[2] && lat_b < 0) lat_b = snap_cyc;
        end
        wv = 1'b0;
        we6 = s6[34];
        we61 = s61[34];
        chk_eq("b_ready_idle", r5, 1'b1);
        chk_eq("b_we_next", we6, 1'b1);
        chk_eq("b_waddr", s6[33:26], 8'h12);
        chk_eq("b_wdata", s6[25:10], 16'hBEEF);
        chk_eq("b_we_one_cycle", we7, 1'b0);
        chk_eq("b_we_before_tick", we61, 1'b1);
        chk_eq("b_waddr_before_tick", s61[33:26], 8'h34);
        chk_eq("b_ready_pending", r64, 1'b0);
        chk_eq("b_handshake_cycle", hs, HS_EXP);
        chk_eq("b_late_write_cycle", we_c, HS_EXP + 1);
        chk_eq("b_out_latch_cycle", lat_b, LAT_EXP);

        // Phase D: reset in the middle of a sweep.
        do_reset();
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (alu[0] && chs[0] == 2'd2 && stp[0] == 3'd5) found = 1;
            else do_cycle();
        end
        chk_eq("d_reach_ch2_step5", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("d_rst_outs0", obs_vec(0), 36'd0);
        chk_eq("d_rst_outs1", obs_vec(1), 36'd0);
        do_cycle();
        rst_n = 1'b1;
        cyc = 0;
        nlat = 0;
        first_acc = -1;
        for (int c = 0; c < 90; c++) begin
            do_cycle();
            if (snap0[2] || snap0[34]) nlat++;
            if (snap0[3] && first_acc < 0) first_acc = snap_cyc;
        end
        chk_eq("d_no_pulse_after_rst", nlat, 0);
        chk_eq("d_restart_acc_clear", first_acc, 65);

        // Phase C: randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            en    = ($urandom_range(0, 15) != 0);
            wv    = ($urandom_range(0, 3) == 0);
            wa    = 8'($urandom);
            wd    = 16'($urandom);
            ocl   = ($urandom_range(0, 31) == 0);
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwls_channel_scheduler.md
PWLS_CHANNEL_SCHEDULER -- requirements
Module: pwls_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of synth channels time-multiplexed onto the shared multichannel ALU.
REQ-002 SHALL have parameter STEPS, default 8: ALU cycles spent per channel per sweep.
REQ-003 SHALL have parameter SAMPLE_DIV, default 64: clk cycles per output sample period.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset.
REQ-005 SHALL have ports: en in 1, sample timebase enable; overrun_clr in 1, clears overrun.
REQ-006 SHALL have ports: wr_valid in 1, wr_addr in 8, wr_data in 16 (host register write request); wr_ready out 1, write accept.
REQ-007 SHALL have ports: reg_we out 1, reg_waddr out 8, reg_wdata out 16, registered write strobe/address/data to ALU register file.
REQ-008 SHALL have ports: ch_sel out clog2(NUM_CH), step out clog2(STEPS), alu_en out 1, acc_clear out 1, out_latch out 1, busy out 1, overrun out 1.
REQ-009 SHALL use one clock, clk; reset is asynchronous and active-low, port rst_n.

Function
REQ-010 SHALL run sample counter 0..SAMPLE_DIV-1 while en=1, wrapping to 0; tick = (counter==SAMPLE_DIV-1 and en=1).
REQ-011 SHALL hold counter at 0 and generate no ticks while en=0; an in-progress sweep still completes.
REQ-012 SHALL set pending at the edge following a tick; if pending is already 1 at that tick, SHALL set overrun (sticky).
REQ-013 SHALL clear overrun on overrun_clr=1; simultaneous set and clear: set wins.
REQ-014 SHALL implement states IDLE, RUN, WRITE.
REQ-015 IDLE: pending=1 -> RUN with ch_sel=0, step=0, pending cleared; else wr_valid=1 -> WRITE; else stay. Pending sweep beats write.
REQ-016 wr_ready SHALL be combinational: 1 only in IDLE with pending=0 (plus REQ-027 slots); transfer when wr_valid and wr_ready.
REQ-017 On transfer SHALL capture wr_addr/wr_data into reg_waddr/reg_wdata; in WRITE (exactly one cycle) reg_we=1, then return to IDLE.
REQ-018 RUN: alu_en=1; step increments each cycle; at step=STEPS-1, step->0 and ch_sel increments.
REQ-019 At ch_sel=NUM_CH-1, step=STEPS-1: SHALL go to IDLE; out_latch=1 for exactly the following cycle.
REQ-020 acc_clear SHALL be 1 exactly in the RUN cycle with ch_sel=0, step=0.
REQ-021 busy SHALL be 1 when state is not IDLE; ch_sel/step SHALL read 0 outside RUN.
REQ-022 Ticks arriving during RUN/WRITE SHALL only set pending (REQ-012); no sweep restarts mid-sweep.
REQ-023 reg_we, alu_en, acc_clear, out_latch SHALL never be 1 in the same cycle as reg_we except out_latch.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, counter=0, pending=0, overrun=0, ch_sel=0, step=0.
REQ-025 All outputs SHALL be 0 during reset, including reg_waddr/reg_wdata; wr_ready=0.
REQ-026 Reset mid-sweep or mid-write SHALL abandon it; no reg_we or out_latch pulse after release until new request/tick.

Configuration
REQ-027 With macro PWLS_SCHED_MIDSWEEP_WRITE_EN defined, wr_ready SHALL also be 1 in RUN at step=STEPS-1 with ch_sel<NUM_CH-1; a transfer there inserts one WRITE cycle, then RUN resumes at ch_sel+1, step=0 (alu_en=0 during WRITE).
REQ-028 Without PWLS_SCHED_MIDSWEEP_WRITE_EN, writes SHALL be accepted only in IDLE per REQ-016; sweep is always NUM_CH*STEPS contiguous cycles.

Verification
REQ-029 Defaults, en=1 from reset release (cycle 0): tick at cycle 63, RUN from cycle 65, alu_en high 32 cycles, acc_clear at 65 only, out_latch at cycle 97; repeats every 64.
REQ-030 IDLE, wr_valid=1, addr=0x12, data=0xBEEF: wr_ready=1 same cycle; next cycle reg_we=1, reg_waddr=0x12, reg_wdata=0xBEEF, one cycle only.
REQ-031 wr_valid held from cycle 60: write completes before cycle 63; wr_valid reasserted at cycle 64 with pending=1 -> wr_ready=0 until sweep ends; write occurs at cycle 98.
REQ-032 SAMPLE_DIV=16: second tick during first sweep sets pending, third tick while pending -> overrun=1; overrun_clr pulse -> overrun=0 unless coincident set.
REQ-033 rst_n low at ch_sel=2, step=5: all outputs 0 immediately; after release no out_latch until next full sweep.
REQ-034 PWLS_SCHED_MIDSWEEP_WRITE_EN defined, wr_valid=1 during sweep: accepted at ch_sel=0, step=7; reg_we next cycle; ch_sel=1, step=0 follows; out_latch 1 cycle later than REQ-029.
